// File: rtl/reg_read_scoreboard.sv
// reg_read_scoreboard: GPR array with two bypassed combinational read ports,
// one write-back port, and a busy-bit scoreboard. The scoreboard stalls ID
// while a source or destination is still owned by a long-latency producer.
module reg_read_scoreboard #(
    parameter  int DATA_W   = 32,
    parameter  int NREG     = 32,
    parameter  int MAX_PEND = 4,
    localparam int AW       = $clog2(NREG),
    localparam int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rs_id,
    input  logic [AW-1:0]     rt_id,
    output logic [DATA_W-1:0] r1_out,
    output logic [DATA_W-1:0] r2_out,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_rw,
    input  logic [DATA_W-1:0] wb_din,
    input  logic              issue_valid,
    input  logic              issue_long,
    input  logic [AW-1:0]     issue_rw,
    output logic              stall,
    output logic [CW-1:0]     pend_cnt
);

    logic [DATA_W-1:0] gpr [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              wb_live;
    logic              hazard_rs;
    logic              hazard_rt;
    logic              pend_full;
    logic              waw;
    logic              issue_set;

    // Number of set bits; the issue gating keeps this at or below MAX_PEND.
    function automatic logic [CW-1:0] count_busy(input logic [NREG-1:0] bits);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < NREG; i++) begin
            n = n + CW'(bits[i]);
        end
        return n;
    endfunction

    // Operand reads: r0 hardwired to zero, same-cycle write-back forwarded.
    always_comb begin
        r1_out = gpr[rs_id];
        if (rs_id == '0) begin
            r1_out = '0;
        end else if (wb_we && (wb_rw == rs_id)) begin
            r1_out = wb_din;
        end
        r2_out = gpr[rt_id];
        if (rt_id == '0) begin
            r2_out = '0;
        end else if (wb_we && (wb_rw == rt_id)) begin
            r2_out = wb_din;
        end
    end

    // Hazard detection; a write-back landing this cycle resolves its own hazard.
    always_comb begin
        wb_live   = wb_we && (wb_rw != '0);
        hazard_rs = busy[rs_id] && !(wb_we && (wb_rw == rs_id));
        hazard_rt = busy[rt_id] && !(wb_we && (wb_rw == rt_id));
        pend_full = issue_valid && issue_long && (pend_cnt == CW'(MAX_PEND))
                    && !(wb_we && busy[wb_rw]);
        waw       = issue_valid && issue_long && busy[issue_rw]
                    && !(wb_we && (wb_rw == issue_rw));
        stall     = hazard_rs || hazard_rt || pend_full || waw;
        issue_set = issue_valid && issue_long && !stall && (issue_rw != '0);
    end

    // Next busy vector: clear on write-back first so a same-register issue wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_live) begin
            busy_nxt[wb_rw] = 1'b0;
        end
        if (issue_set) begin
            busy_nxt[issue_rw] = 1'b1;
        end
    end

    // GPR write port; reset clears the whole array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_live) begin
            gpr[wb_rw] <= wb_din;
        end
    end

    // Scoreboard state; reset drops every in-flight destination.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= count_busy(busy_nxt);
        end
    end

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Testbench for reg_read_scoreboard: directed scenarios plus randomized traffic
// against a reference model, all expectations routed through a queue.
module tb_reg_read_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_id, rt_id, wb_rw, issue_rw;
    logic [31:0] r1_out, r2_out, wb_din;
    logic        wb_we, issue_valid, issue_long, stall;
    logic [2:0]  pend_cnt;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        stall;
        logic [2:0]  pend;
    } obs_t;

    obs_t expq[$];
    int   checks = 0;
    int   passed = 0;

    reg_read_scoreboard dut (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .r1_out(r1_out), .r2_out(r2_out),
        .wb_we(wb_we), .wb_rw(wb_rw), .wb_din(wb_din),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_rw(issue_rw),
        .stall(stall), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input logic [31:0] r1, input logic [31:0] r2,
                                input logic st, input logic [2:0] pc);
        obs_t o;
        o.r1 = r1; o.r2 = r2; o.stall = st; o.pend = pc;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.r1 = r1_out; o.r2 = r2_out; o.stall = stall; o.pend = pend_cnt;
        return o;
    endfunction

    function automatic string show(input obs_t o);
        return $sformatf("r1=%h r2=%h stall=%b pend=%0d", o.r1, o.r2, o.stall, o.pend);
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_id = 0; rt_id = 0; wb_we = 0; wb_rw = 0; wb_din = 0;
        issue_valid = 0; issue_long = 0; issue_rw = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        next();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rw);
        issue_valid = 1; issue_long = 1; issue_rw = rw;
    endtask

    task automatic wb(input logic [4:0] rw, input logic [31:0] d);
        wb_we = 1; wb_rw = rw; wb_din = d;
    endtask

    task automatic test_reset();
        obs_t got, want;
        rst = 1'b1;
        idle();
        next();
        next();
        rst = 1'b0;
        rs_id = 5; rt_id = 0;
        expq.push_back(mk(0, 0, 0, 0));
        #3 got = observe(); want = expq.pop_front(); checks++;
        if (got !== want) $display("FAIL reset_state: got %s, expected %s", show(got), show(want));
        else passed++;
        next();
    endtask

    task automatic test_bypass();
        obs_t got, want;
        obs_t stim [5];
        logic [4:0] rs_s [5], rt_s [5], wr_s [5];
        logic [31:0] d_s [5];
        logic we_s [5];
        // rs, rt, wb_we, wb_rw, wb_din, expected
        rs_s = '{7, 7, 0, 0, 7}; rt_s = '{0, 0, 0, 7, 8};
        we_s = '{1, 0, 1, 0, 1}; wr_s = '{7, 0, 0, 0, 8};
        d_s  = '{32'hDEADBEEF, 0, 32'h1, 0, 32'h12345678};
        stim[0] = mk(32'hDEADBEEF, 0, 0, 0);
        stim[1] = mk(32'hDEADBEEF, 0, 0, 0);
        stim[2] = mk(0, 0, 0, 0);
        stim[3] = mk(0, 32'hDEADBEEF, 0, 0);
        stim[4] = mk(32'hDEADBEEF, 32'h12345678, 0, 0);
        for (int i = 0; i < 5; i++) begin
            idle();
            rs_id = rs_s[i]; rt_id = rt_s[i];
            wb_we = we_s[i]; wb_rw = wr_s[i]; wb_din = d_s[i];
            expq.push_back(stim[i]);
            #3 got = observe(); want = expq.pop_front(); checks++;
            if (got !== want) $display("FAIL bypass_step%0d: got %s, expected %s", i, show(got), show(want));
            else passed++;
            next();
        end
    endtask

    task automatic test_long_issue();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin issue(9); expq.push_back(mk(0, 0, 0, 0)); end
                1: begin rs_id = 9; expq.push_back(mk(0, 0, 1, 1)); end
                2: begin rs_id = 9; wb(9, 32'h55); expq.push_back(mk(32'h55, 0, 0, 1)); end
                default: begin rs_id = 9; expq.push_back(mk(32'h55, 0, 0, 0)); end
            endcase
            #3 got = observe(); want = expq.pop_front(); checks++;
            if (got !== want) $display("FAIL long_issue_step%0d: got %s, expected %s", i, show(got), show(want));
            else passed++;
            next();
        end
    endtask

    task automatic test_max_pend();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i < 4) begin
                issue(5'(i + 1));
                expq.push_back(mk(0, 0, 0, 3'(i)));
            end else begin
                case (i)
                    4: begin issue(5); expq.push_back(mk(0, 0, 1, 4)); end
                    5: begin issue(6); wb(7, 32'h7); expq.push_back(mk(0, 0, 1, 4)); end
                    6: begin issue(5); wb(2, 32'h22); expq.push_back(mk(0, 0, 0, 4)); end
                    default: begin rs_id = 5; rt_id = 2; expq.push_back(mk(0, 32'h22, 1, 4)); end
                endcase
            end
            #3 got = observe(); want = expq.pop_front(); checks++;
            if (got !== want) $display("FAIL max_pend_step%0d: got %s, expected %s", i, show(got), show(want));
            else passed++;
            next();
        end
    endtask

    task automatic test_waw();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: begin issue(9); expq.push_back(mk(0, 0, 0, 0)); end
                1: begin issue(9); wb(9, 32'h77); expq.push_back(mk(0, 0, 0, 1)); end
                2: begin rs_id = 9; expq.push_back(mk(32'h77, 0, 1, 1)); end
                3: begin issue(9); expq.push_back(mk(0, 0, 1, 1)); end
                default: expq.push_back(mk(0, 0, 0, 1));
            endcase
            #3 got = observe(); want = expq.pop_front(); checks++;
            if (got !== want) $display("FAIL waw_step%0d: got %s, expected %s", i, show(got), show(want));
            else passed++;
            next();
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, want;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: begin issue(3); expq.push_back(mk(0, 0, 0, 0)); end
                1: begin issue(4); expq.push_back(mk(0, 0, 0, 1)); end
                2: begin rs_id = 3; rt_id = 4; expq.push_back(mk(0, 0, 1, 2)); end
                3: begin
                    rst = 1'b1;
                    next();
                    rst = 1'b0;
                    rs_id = 3; rt_id = 4;
                    expq.push_back(mk(0, 0, 0, 0));
                end
                4: begin issue(0); wb(3, 32'hAB); rs_id = 3; expq.push_back(mk(32'hAB, 0, 0, 0)); end
                default: begin rs_id = 3; expq.push_back(mk(32'hAB, 0, 0, 0)); end
            endcase
            #3 got = observe(); want = expq.pop_front(); checks++;
            if (got !== want) $display("FAIL reset_mid_step%0d: got %s, expected %s", i, show(got), show(want));
            else passed++;
            next();
        end
    endtask

    task automatic test_random();
        obs_t got, want;
        logic [31:0] gm [32];
        logic [31:0] bm;
        int pc;
        do_reset();
        for (int r = 0; r < 32; r++) gm[r] = 0;
        bm = 0;
        for (int n = 0; n < 300; n++) begin
            rs_id       = 5'($urandom_range(0, 7));
            rt_id       = 5'($urandom_range(0, 7));
            wb_we       = ($urandom_range(0, 9) < 4);
            wb_rw       = 5'($urandom_range(0, 7));
            wb_din      = $urandom();
            issue_valid = 1'($urandom_range(0, 1));
            issue_long  = 1'($urandom_range(0, 1));
            issue_rw    = 5'($urandom_range(0, 7));
            pc = $countones(bm);
            want.r1 = (rs_id == 0) ? 32'h0 : ((wb_we && wb_rw == rs_id) ? wb_din : gm[rs_id]);
            want.r2 = (rt_id == 0) ? 32'h0 : ((wb_we && wb_rw == rt_id) ? wb_din : gm[rt_id]);
            want.stall = (bm[rs_id] && !(wb_we && wb_rw == rs_id))
                      || (bm[rt_id] && !(wb_we && wb_rw == rt_id))
                      || (issue_valid && issue_long && pc == 4 && !(wb_we && bm[wb_rw]))
                      || (issue_valid && issue_long && bm[issue_rw] && !(wb_we && wb_rw == issue_rw));
            want.pend = 3'(pc);
            expq.push_back(want);
            #3 got = observe(); want = expq.pop_front(); checks++;
            if (got !== want) $display("FAIL random_cycle%0d: got %s, expected %s", n, show(got), show(want));
            else passed++;
            if (wb_we && wb_rw != 0) begin
                gm[wb_rw] = wb_din;
                bm[wb_rw] = 1'b0;
            end
            if (issue_valid && issue_long && !want.stall && issue_rw != 0) bm[issue_rw] = 1'b1;
            next();
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_long_issue();
        test_max_pend();
        test_waw();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
